ptw_arbiter: RTL and testbench

//  Shares one page-table walker between the I-TLB and D-TLB miss ports.
//  - Grants one walk at a time, latches the walk VA and tags the owner.
//  - Routes the walker's finish/PTE back to the owning TLB only.
//  - Discards in-flight results on fence flush.
//  - D-side has priority; a starvation limit guarantees I-side progress.

---
 rtl/ptw_arbiter.sv | 101 ++++++++++
 tb/tb_ptw_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ptw_arbiter.sv
// Arbitrates one page-table walker between the I-TLB and D-TLB miss ports.
// D-side wins ties until I-side has been passed over STARVE_LIMIT times in a row.
module ptw_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fence_flush,
  input  logic                  ren_i,
  input  logic [ADDR_WIDTH-1:0] va_i,
  output logic                  rvalid_i,
  input  logic                  ren_d,
  input  logic [ADDR_WIDTH-1:0] va_d,
  output logic                  rvalid_d,
  output logic [DATA_WIDTH-1:0] pte_out,
  output logic                  twu_req,
  output logic [ADDR_WIDTH-1:0] twu_va,
  input  logic [DATA_WIDTH-1:0] twu_pte,
  input  logic                  twu_finish,
  output logic [1:0]            owner,
  output logic                  draining
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WALK_I, WALK_D, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] twu_va_q, twu_va_d;
  logic [1:0]            owner_q, owner_d;
  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      twu_va_q     <= '0;
      owner_q      <= 2'b00;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      twu_va_q     <= twu_va_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    twu_va_d     = twu_va_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_i     = 1'b0;
    rvalid_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        owner_d = 2'b00;
        if (!fence_flush) begin
          if (ren_d && (!ren_i || starve_cnt_q < LIMIT)) begin
            state_d  = WALK_D;
            twu_va_d = va_d;
            owner_d  = 2'b10;
            if (ren_i && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
          end else if (ren_i) begin
            state_d      = WALK_I;
            twu_va_d     = va_i;
            owner_d      = 2'b01;
            starve_cnt_d = '0;
          end
        end
      end
      WALK_I, WALK_D: begin
        if (twu_finish) begin
          // a flush landing on the finish cycle swallows the result
          rvalid_i = !fence_flush && (state_q == WALK_I);
          rvalid_d = !fence_flush && (state_q == WALK_D);
          state_d  = IDLE;
          owner_d  = 2'b00;
        end else if (fence_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (twu_finish) begin
          state_d = IDLE;
          owner_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign twu_req  = (state_q != IDLE);
  assign twu_va   = twu_va_q;
  assign owner    = owner_q;
  assign draining = (state_q == DRAIN);
  assign pte_out  = twu_pte;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: reset, lone/simultaneous misses, starvation, flushes.
module tb_ptw_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fence_flush = 1'b0;
  logic        ren_i = 1'b0, ren_d = 1'b0;
  logic [63:0] va_i = '0, va_d = '0;
  logic        rvalid_i, rvalid_d;
  logic [63:0] pte_out, twu_va, twu_pte = '0;
  logic        twu_req, twu_finish = 1'b0, draining;
  logic [1:0]  owner;

  int n_chk = 0;
  int n_fail = 0;

  ptw_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .fence_flush(fence_flush),
    .ren_i(ren_i), .va_i(va_i), .rvalid_i(rvalid_i),
    .ren_d(ren_d), .va_d(va_d), .rvalid_d(rvalid_d),
    .pte_out(pte_out), .twu_req(twu_req), .twu_va(twu_va),
    .twu_pte(twu_pte), .twu_finish(twu_finish),
    .owner(owner), .draining(draining)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // power-on reset
    tick(); tick();
    chk("rst_req", {63'd0, twu_req}, 64'd0);
    chk("rst_owner", {62'd0, owner}, 64'd0);
    chk("rst_va", twu_va, 64'd0);
    chk("rst_drain", {63'd0, draining}, 64'd0);
    rst = 1'b0;
    tick();

    // lone I miss
    ren_i = 1'b1; va_i = 64'h8000_1000;
    #1 chk("i_req_pre", {63'd0, twu_req}, 64'd0);
    tick();
    chk("i_req", {63'd0, twu_req}, 64'd1);
    chk("i_va", twu_va, 64'h8000_1000);
    chk("i_owner", {62'd0, owner}, 64'd1);
    tick();
    twu_finish = 1'b1; twu_pte = 64'h2000_04CF;
    #1;
    chk("i_rvalid_i", {63'd0, rvalid_i}, 64'd1);
    chk("i_rvalid_d", {63'd0, rvalid_d}, 64'd0);
    chk("i_pte", pte_out, 64'h2000_04CF);
    tick();
    twu_finish = 1'b0; ren_i = 1'b0;
    chk("i_idle_req", {63'd0, twu_req}, 64'd0);
    chk("i_idle_owner", {62'd0, owner}, 64'd0);

    // simultaneous miss: D first, then I
    ren_i = 1'b1; va_i = 64'h2000; ren_d = 1'b1; va_d = 64'h1000;
    tick();
    chk("sim_owner_d", {62'd0, owner}, 64'd2);
    chk("sim_va_d", twu_va, 64'h1000);
    chk("sim_cnt1", 64'(dut.starve_cnt_q), 64'd1);
    twu_finish = 1'b1;
    #1;
    chk("sim_rvalid_d", {63'd0, rvalid_d}, 64'd1);
    chk("sim_rvalid_i", {63'd0, rvalid_i}, 64'd0);
    tick();
    twu_finish = 1'b0; ren_d = 1'b0;
    chk("sim_idle", {63'd0, twu_req}, 64'd0);
    tick();
    chk("sim_owner_i", {62'd0, owner}, 64'd1);
    chk("sim_va_i", twu_va, 64'h2000);
    chk("sim_cnt0", 64'(dut.starve_cnt_q), 64'd0);
    twu_finish = 1'b1;
    #1 chk("sim_rvalid_i2", {63'd0, rvalid_i}, 64'd1);
    tick();
    twu_finish = 1'b0; ren_i = 1'b0;

    // starvation: I held while D streams misses
    ren_i = 1'b1; va_i = 64'h9000; ren_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      va_d = 64'hA000 + 64'(k);
      tick();
      chk("stv_owner_d", {62'd0, owner}, 64'd2);
      chk("stv_va_d", twu_va, 64'hA000 + 64'(k));
      chk("stv_cnt", 64'(dut.starve_cnt_q), 64'(k + 1));
      twu_finish = 1'b1;
      #1 chk("stv_rvalid_d", {63'd0, rvalid_d}, 64'd1);
      tick();
      twu_finish = 1'b0;
    end
    tick();
    chk("stv_forced_i", {62'd0, owner}, 64'd1);
    chk("stv_va_i", twu_va, 64'h9000);
    chk("stv_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
    twu_finish = 1'b1;
    #1 chk("stv_rvalid_i", {63'd0, rvalid_i}, 64'd1);
    tick();
    twu_finish = 1'b0; ren_i = 1'b0;
    for (int k = 4; k < 6; k++) begin
      va_d = 64'hA000 + 64'(k);
      tick();
      chk("stv_tail_d", {62'd0, owner}, 64'd2);
      twu_finish = 1'b1;
      tick();
      twu_finish = 1'b0;
    end
    ren_d = 1'b0;
    chk("stv_tail_cnt", 64'(dut.starve_cnt_q), 64'd0);

    // flush mid-walk in WALK_I
    ren_i = 1'b1; va_i = 64'h3000;
    tick();
    chk("fl_owner", {62'd0, owner}, 64'd1);
    fence_flush = 1'b1; ren_i = 1'b0;
    tick();
    fence_flush = 1'b0;
    chk("fl_draining", {63'd0, draining}, 64'd1);
    chk("fl_req", {63'd0, twu_req}, 64'd1);
    chk("fl_owner_hold", {62'd0, owner}, 64'd1);
    fence_flush = 1'b1;
    tick();
    fence_flush = 1'b0;
    chk("fl_reflush", {63'd0, draining}, 64'd1);
    tick();
    twu_finish = 1'b1; twu_pte = 64'hDEAD;
    #1 chk("fl_no_rvalid", {63'd0, rvalid_i}, 64'd0);
    tick();
    twu_finish = 1'b0;
    chk("fl_idle_drain", {63'd0, draining}, 64'd0);
    chk("fl_idle_req", {63'd0, twu_req}, 64'd0);

    // flush coincident with finish in WALK_D, I pending
    ren_d = 1'b1; va_d = 64'h4000;
    tick();
    ren_d = 1'b0; ren_i = 1'b1; va_i = 64'h5000;
    fence_flush = 1'b1; twu_finish = 1'b1;
    #1;
    chk("ff_rvalid_d", {63'd0, rvalid_d}, 64'd0);
    chk("ff_rvalid_i", {63'd0, rvalid_i}, 64'd0);
    tick();
    fence_flush = 1'b0; twu_finish = 1'b0;
    chk("ff_idle", {63'd0, twu_req}, 64'd0);
    chk("ff_drain", {63'd0, draining}, 64'd0);
    tick();
    chk("ff_grant_i", {62'd0, owner}, 64'd1);
    chk("ff_va_i", twu_va, 64'h5000);
    twu_finish = 1'b1;
    tick();
    twu_finish = 1'b0; ren_i = 1'b0;

    // flush in IDLE blocks that cycle's grant
    ren_i = 1'b1; va_i = 64'h6000; fence_flush = 1'b1;
    tick();
    chk("idle_fl_block", {63'd0, twu_req}, 64'd0);
    fence_flush = 1'b0;
    tick();
    chk("idle_fl_grant", {63'd0, twu_req}, 64'd1);
    twu_finish = 1'b1;
    tick();
    twu_finish = 1'b0; ren_i = 1'b0;

    // async reset mid-WALK_D
    ren_d = 1'b1; va_d = 64'h7000;
    tick();
    chk("ar_walk", {62'd0, owner}, 64'd2);
    rst = 1'b1;
    #1;
    chk("ar_req", {63'd0, twu_req}, 64'd0);
    chk("ar_owner", {62'd0, owner}, 64'd0);
    chk("ar_va", twu_va, 64'd0);
    ren_d = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_idle", {63'd0, twu_req}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
